lsu_mem_master: RTL and testbench

- Load/store initiator that drives the word-addressed data memory (read flag, write flag, 5-bit word address, write value, combinational read-out, write on posedge).
- Sits between the execute stage and data memory.
- Accepts one byte-addressed load/store request at a time over a valid/ready handshake.
- Performs byte, halfword or word access, including read-modify-write for sub-word stores, sign/zero extension for loads, and misalignment checking.
- Returns a single-cycle response pulse.

---
 rtl/lsu_mem_master.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-addressed data memory.
// Handles one byte/half/word request at a time, with read-modify-write for sub-word stores.
module lsu_mem_master #(
    parameter int WORD_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [WORD_ADDR_W+1:0] req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic                   mem_read_flag,
    output logic                   mem_write_flag,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                 state_reg, state_next;
    logic                   we_reg;
    logic [1:0]             size_reg;
    logic                   unsigned_reg;
    logic [WORD_ADDR_W+1:0] addr_reg;
    logic [31:0]            wdata_reg;
    logic [31:0]            rdata_reg;
    logic                   err_reg;

    logic                   req_err;
    logic [7:0]             lane_byte;
    logic [15:0]            lane_half;
    logic [31:0]            load_data;
    logic [31:0]            merged_word;
    logic [3:0]             lane_hit;

    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Load lane extraction from the word currently presented by memory.
    always_comb begin
        lane_byte = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
        lane_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_reg)
            2'b00:   load_data = {{24{~unsigned_reg & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{~unsigned_reg & lane_half[15]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Sub-word store merge: each byte lane either keeps memory data or takes a store byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] new_byte;
            assign lane_hit[gi] = (size_reg == 2'b00) ? (addr_reg[1:0] == LANE)
                                                      : (addr_reg[1] == LANE[1]);
            assign new_byte = (size_reg == 2'b00 || !LANE[0]) ? wdata_reg[7:0] : wdata_reg[15:8];
            assign merged_word[8*gi +: 8] = lane_hit[gi] ? new_byte : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_we || req_size != 2'b10)
                        state_next = READ;
                    else
                        state_next = WRITE;
                end
            end
            READ:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg       <= req_we;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        err_reg      <= req_err;
                        rdata_reg    <= 32'h0;
                    end
                end
                READ: begin
                    // A store reuses wdata_reg to carry the merged word into WRITE.
                    if (we_reg)
                        wdata_reg <= merged_word;
                    else
                        rdata_reg <= load_data;
                end
                RESP: begin
                    rdata_reg <= 32'h0;
                    err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready      = (state_reg == IDLE);
        resp_valid     = (state_reg == RESP);
        resp_rdata     = rdata_reg;
        resp_err       = err_reg;
        mem_read_flag  = (state_reg == READ);
        mem_write_flag = (state_reg == WRITE);
        mem_addr       = '0;
        mem_wdata      = 32'h0;
        if (state_reg == READ || state_reg == WRITE)
            mem_addr = addr_reg[WORD_ADDR_W+1:2];
        if (state_reg == WRITE)
            mem_wdata = wdata_reg;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized and directed bench for lsu_mem_master against a behavioural memory model.
module tb_lsu_mem_master;

    localparam int W = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [W+1:0]  req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_read_flag;
    logic          mem_write_flag;
    logic [W-1:0]  mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   tb_mem  [32];
    logic [31:0]   ref_mem [32];
    logic          mem_init = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.WORD_ADDR_W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory: combinational read, write on rising edge.
    assign mem_rdata = mem_read_flag ? tb_mem[mem_addr] : 32'h0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= 32'h0;
        end else if (mem_write_flag) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issues one request from IDLE (called just after a falling edge) and checks it end to end.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [6:0] addr, input logic [31:0] wdata,
                           output logic [31:0] obs_rdata);
        int          off, widx, exp_lat, exp_reads, exp_writes;
        int          lat, reads, writes, both;
        logic        exp_err, got;
        logic [31:0] old, v, exp_rdata, new_word, mask;
        off  = int'(addr[1:0]);
        widx = int'(addr[6:2]);
        old  = ref_mem[widx];
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        exp_rdata = 32'h0;
        new_word  = old;
        exp_reads = 0;
        exp_writes = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_reads = 1;
            if (size == 2'd0) begin
                v = (old >> (8 * off)) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                v = (old >> (8 * off)) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = old;
            end
            exp_rdata = v;
        end else if (size == 2'd2) begin
            exp_lat = 2;
            exp_writes = 1;
            new_word = wdata;
        end else begin
            exp_lat = 3;
            exp_reads = 1;
            exp_writes = 1;
            mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            new_word = (old & ~mask) | ((wdata << (8 * off)) & mask);
        end

        check("ready_idle", 32'(req_ready), 32'h1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 0; reads = 0; writes = 0; both = 0; got = 1'b0;
        obs_rdata = 32'h0;
        for (int c = 1; c <= 6 && !got; c++) begin
            if (c == 1) check("ready_busy", 32'(req_ready), 32'h0);
            if (mem_read_flag && mem_write_flag) both++;
            if (mem_read_flag) begin
                reads++;
                check("rd_addr", 32'(mem_addr), 32'(widx));
            end
            if (mem_write_flag) begin
                writes++;
                check("wr_addr", 32'(mem_addr), 32'(widx));
                check("wr_data", mem_wdata, new_word);
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
                obs_rdata = resp_rdata;
                check("resp_ready", 32'(req_ready), 32'h0);
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
            end else begin
                @(negedge clk);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("reads", 32'(reads), 32'(exp_reads));
        check("writes", 32'(writes), 32'(exp_writes));
        check("rw_excl", 32'(both), 32'h0);
        @(negedge clk);
        check("pulse_end", 32'(resp_valid), 32'h0);
        check("rdata_clr", resp_rdata, 32'h0);
        check("err_clr", 32'(resp_err), 32'h0);
        if (we && !exp_err) ref_mem[widx] = new_word;
        check("mem_word", tb_mem[widx], ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] r;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'h0);
        check("rst_mem_rd", 32'(mem_read_flag), 32'h0);
        check("rst_mem_wr", 32'(mem_write_flag), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);

        run_req(1'b1, 2'd2, 1'b0, 7'h08, 32'hDEADBEEF, r);
        run_req(1'b0, 2'd2, 1'b0, 7'h08, 32'h0, r);
        check("tp_word_load", r, 32'hDEADBEEF);

        run_req(1'b1, 2'd2, 1'b0, 7'h08, 32'h80FF7F01, r);
        run_req(1'b0, 2'd0, 1'b0, 7'h08, 32'h0, r);
        check("tp_b0s", r, 32'h00000001);
        run_req(1'b0, 2'd0, 1'b0, 7'h09, 32'h0, r);
        check("tp_b1s", r, 32'h0000007F);
        run_req(1'b0, 2'd0, 1'b0, 7'h0A, 32'h0, r);
        check("tp_b2s", r, 32'hFFFFFFFF);
        run_req(1'b0, 2'd0, 1'b0, 7'h0B, 32'h0, r);
        check("tp_b3s", r, 32'hFFFFFF80);
        run_req(1'b0, 2'd0, 1'b1, 7'h0B, 32'h0, r);
        check("tp_b3u", r, 32'h00000080);

        run_req(1'b1, 2'd2, 1'b0, 7'h14, 32'h11223344, r);
        run_req(1'b1, 2'd0, 1'b0, 7'h16, 32'h000000AA, r);
        run_req(1'b1, 2'd1, 1'b0, 7'h14, 32'h0000BEEF, r);
        run_req(1'b0, 2'd2, 1'b0, 7'h14, 32'h0, r);
        check("tp_rmw_word", r, 32'h11AABEEF);

        run_req(1'b0, 2'd1, 1'b0, 7'h03, 32'h0, r);
        run_req(1'b1, 2'd2, 1'b0, 7'h06, 32'h12345678, r);
        run_req(1'b0, 2'd3, 1'b0, 7'h00, 32'h0, r);
        run_req(1'b1, 2'd3, 1'b0, 7'h04, 32'hFFFFFFFF, r);

        // Back-to-back loads with req_valid held: one acceptance every three cycles.
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 7'h08;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("b2b_ready", 32'(req_ready), 32'((i % 3) == 0));
            check("b2b_resp", 32'(resp_valid), 32'((i % 3) == 2));
            if (resp_valid) check("b2b_rdata", resp_rdata, ref_mem[2]);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_idle", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("b2b_quiet", 32'(resp_valid), 32'h0);

        // Reset asserted while a word store sits in WRITE.
        req_we = 1'b1; req_size = 2'd2; req_addr = 7'h0C; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_write", 32'(mem_write_flag), 32'h1);
        rst = 1'b0;
        #1;
        check("abort_wr", 32'(mem_write_flag), 32'h0);
        check("abort_rd", 32'(mem_read_flag), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h0);
        check("abort_wdata", mem_wdata, 32'h0);
        check("abort_resp", 32'(resp_valid), 32'h0);
        check("abort_rdata", resp_rdata, 32'h0);
        check("abort_err", 32'(resp_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check("abort_mem", tb_mem[3], ref_mem[3]);
        check("abort_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_noresp", 32'(resp_valid), 32'h0);
        end

        for (int n = 0; n < 300; n++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), $urandom, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
